// File: rtl/rt_pixel_sink.sv
// Receiving end of the rt_core pixel stream: show-ahead FIFO with stall backpressure,
// re-emitted as an AXI4-Stream master with SOF/EOF tagging and frame-length checking.
module rt_pixel_sink #(
  parameter int unsigned FP_WL           = 16,
  parameter int unsigned COORDINATE_BITS = 8,
  parameter int unsigned DEPTH           = 16,
  parameter int unsigned SKID            = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       frame_start,
  input  logic [COORDINATE_BITS-1:0] image_width,
  input  logic [COORDINATE_BITS-1:0] image_height,
  input  logic                       in_valid,
  input  logic                       in_last,
  input  logic [FP_WL-1:0]           in_pixel,
  output logic                       stall,
  output logic                       m_tvalid,
  input  logic                       m_tready,
  output logic [FP_WL-1:0]           m_tdata,
  output logic                       m_tlast,
  output logic                       m_tuser,
  output logic                       frame_err,
  output logic                       overflow,
  output logic [15:0]                frames_done
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned PW = 2 * COORDINATE_BITS;

  typedef struct packed {
    logic             last;
    logic             sof;
    logic [FP_WL-1:0] pixel;
  } beat_t;

  beat_t          r_mem [DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [CW-1:0]  r_count;
  logic           r_stall;
  logic           r_frame_err;
  logic           r_overflow;
  logic [15:0]    r_frames_done;
  logic [PW-1:0]  r_expected;
  logic [PW-1:0]  r_pix_cnt;
  logic           r_active;
  logic           r_sof_pending;

  logic           w_pop;
  logic           w_push;
  logic [CW-1:0]  w_count_next;
  logic [PW-1:0]  w_exp_eff;
  logic [PW-1:0]  w_cnt_eff;
  logic [PW-1:0]  w_cnt_inc;
  logic           w_active_eff;
  logic           w_sof_eff;
  logic           w_len_err;
  beat_t          w_head;

  // A full FIFO still accepts a push when the head leaves in the same cycle
  assign w_pop        = m_tvalid && m_tready;
  assign w_push       = in_valid && ((r_count < CW'(DEPTH)) || w_pop);
  assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);

  // frame_start coinciding with a push makes that beat the first of the new frame
  assign w_exp_eff    = frame_start ? (PW'(image_width) * PW'(image_height)) : r_expected;
  assign w_cnt_eff    = frame_start ? '0 : r_pix_cnt;
  assign w_active_eff = frame_start || r_active;
  assign w_sof_eff    = frame_start || r_sof_pending;
  assign w_cnt_inc    = w_cnt_eff + PW'(1);
  assign w_len_err    = !w_active_eff
                     || ( in_last && (w_cnt_inc != w_exp_eff))
                     || (!in_last && (w_cnt_inc == w_exp_eff));

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_stall       <= 1'b0;
      r_frame_err   <= 1'b0;
      r_overflow    <= 1'b0;
      r_frames_done <= '0;
      r_expected    <= '0;
      r_pix_cnt     <= '0;
      r_active      <= 1'b0;
      r_sof_pending <= 1'b0;
    end else begin
      r_count <= w_count_next;
      r_stall <= (w_count_next >= CW'(DEPTH - SKID));
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);

      if (frame_start) begin
        r_expected    <= w_exp_eff;
        r_pix_cnt     <= '0;
        r_active      <= 1'b1;
        r_sof_pending <= 1'b1;
      end

      if (in_valid && !w_push) r_overflow <= 1'b1;

      if (w_push) begin
        r_mem[r_wr_ptr] <= '{last: in_last, sof: w_sof_eff, pixel: in_pixel};
        r_wr_ptr        <= r_wr_ptr + AW'(1);
        r_sof_pending   <= 1'b0;
        if (w_len_err) r_frame_err <= 1'b1;
        if (in_last) begin
          r_frames_done <= r_frames_done + 16'd1;
          r_pix_cnt     <= '0;
          r_active      <= 1'b0;
        end else begin
          r_pix_cnt     <= w_cnt_inc;
        end
      end
    end
  end

  // Show-ahead head; forced to zero while empty so idle outputs are clean
  assign w_head      = r_mem[r_rd_ptr];
  assign m_tvalid    = (r_count != '0);
  assign m_tdata     = m_tvalid ? w_head.pixel : '0;
  assign m_tlast     = m_tvalid && w_head.last;
  assign m_tuser     = m_tvalid && w_head.sof;
  assign stall       = r_stall;
  assign frame_err   = r_frame_err;
  assign overflow    = r_overflow;
  assign frames_done = r_frames_done;

endmodule

// File: tb/tb_rt_pixel_sink.sv
// Directed self-checking bench for rt_pixel_sink (DEPTH=16, SKID=4).
module tb_rt_pixel_sink;

  localparam int unsigned FP_WL = 16;
  localparam int unsigned CB    = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             frame_start;
  logic [CB-1:0]    image_width;
  logic [CB-1:0]    image_height;
  logic             in_valid;
  logic             in_last;
  logic [FP_WL-1:0] in_pixel;
  logic             stall;
  logic             m_tvalid;
  logic             m_tready;
  logic [FP_WL-1:0] m_tdata;
  logic             m_tlast;
  logic             m_tuser;
  logic             frame_err;
  logic             overflow;
  logic [15:0]      frames_done;

  typedef struct packed {
    logic [FP_WL-1:0] d;
    logic             l;
    logic             u;
  } ob_t;

  ob_t q[$];
  int  checks   = 0;
  int  failures = 0;

  always #5 clk = ~clk;

  rt_pixel_sink #(.FP_WL(FP_WL), .COORDINATE_BITS(CB), .DEPTH(16), .SKID(4)) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start),
    .image_width(image_width), .image_height(image_height),
    .in_valid(in_valid), .in_last(in_last), .in_pixel(in_pixel),
    .stall(stall), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tdata(m_tdata), .m_tlast(m_tlast), .m_tuser(m_tuser),
    .frame_err(frame_err), .overflow(overflow), .frames_done(frames_done)
  );

  // Record the beat that will pop at the coming edge, then advance one cycle
  task automatic cyc();
    ob_t e;
    if (m_tvalid && m_tready) begin
      e.d = m_tdata; e.l = m_tlast; e.u = m_tuser;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    frame_start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_pixel = '0;
  endtask

  task automatic beat(input logic fs, input logic last, input int pix);
    frame_start = fs; in_valid = 1'b1; in_last = last; in_pixel = FP_WL'(pix);
    cyc();
  endtask

  task automatic do_reset();
    idle();
    m_tready = 1'b0;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if ({m_tvalid, stall, m_tlast, m_tuser} !== 4'b0000) begin
      failures++; $display("FAIL reset_ctrl got=%b want=0000", {m_tvalid, stall, m_tlast, m_tuser}); end
    checks++; if (m_tdata !== '0) begin
      failures++; $display("FAIL reset_tdata got=%h want=0", m_tdata); end
    checks++; if ({frame_err, overflow, frames_done} !== 18'd0) begin
      failures++; $display("FAIL reset_flags err=%b ovf=%b done=%0d want 0/0/0", frame_err, overflow, frames_done); end
  endtask

  task automatic test_basic();
    logic stall_seen;
    ob_t  want;
    do_reset();
    stall_seen = 1'b0;
    m_tready = 1'b1; image_width = 8'd4; image_height = 8'd2;
    frame_start = 1'b1; cyc(); frame_start = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      beat(1'b0, i == 8, i);
      stall_seen |= stall;
    end
    idle();
    repeat (3) begin cyc(); stall_seen |= stall; end
    checks++; if (q.size() != 8) begin
      failures++; $display("FAIL basic_count got=%0d want=8", q.size()); end
    for (int k = 0; k < 8 && k < q.size(); k++) begin
      want.d = FP_WL'(k + 1); want.l = (k == 7); want.u = (k == 0);
      checks++; if (q[k] !== want) begin
        failures++; $display("FAIL basic_beat%0d got d=%0d l=%b u=%b want d=%0d l=%b u=%b",
                             k, q[k].d, q[k].l, q[k].u, want.d, want.l, want.u); end
    end
    checks++; if (frames_done !== 16'd1 || frame_err !== 1'b0) begin
      failures++; $display("FAIL basic_status done=%0d err=%b want 1/0", frames_done, frame_err); end
    checks++; if (stall_seen !== 1'b0) begin
      failures++; $display("FAIL basic_stall got=%b want=0", stall_seen); end
  endtask

  task automatic test_backpressure();
    ob_t want;
    do_reset();
    image_width = 8'd12; image_height = 8'd1;
    for (int i = 1; i <= 12; i++) begin
      beat(i == 1, i == 12, i);
      if (i == 11) begin
        checks++; if (stall !== 1'b0) begin
          failures++; $display("FAIL bp_stall_11 got=%b want=0", stall); end
      end
    end
    idle();
    checks++; if (stall !== 1'b1) begin
      failures++; $display("FAIL bp_stall_12 got=%b want=1", stall); end
    checks++; if (m_tdata !== 16'd1 || m_tuser !== 1'b1) begin
      failures++; $display("FAIL bp_head_stable got d=%0d u=%b want d=1 u=1", m_tdata, m_tuser); end
    m_tready = 1'b1;
    cyc();
    checks++; if (stall !== 1'b0) begin
      failures++; $display("FAIL bp_stall_release got=%b want=0", stall); end
    repeat (14) cyc();
    checks++; if (q.size() != 12) begin
      failures++; $display("FAIL bp_count got=%0d want=12", q.size()); end
    for (int k = 0; k < 12 && k < q.size(); k++) begin
      want.d = FP_WL'(k + 1); want.l = (k == 11); want.u = (k == 0);
      checks++; if (q[k] !== want) begin
        failures++; $display("FAIL bp_beat%0d got d=%0d l=%b u=%b want d=%0d l=%b u=%b",
                             k, q[k].d, q[k].l, q[k].u, want.d, want.l, want.u); end
    end
    checks++; if (frames_done !== 16'd1 || frame_err !== 1'b0) begin
      failures++; $display("FAIL bp_status done=%0d err=%b want 1/0", frames_done, frame_err); end
  endtask

  task automatic test_overflow();
    do_reset();
    image_width = 8'd32; image_height = 8'd1;
    for (int i = 1; i <= 17; i++) begin
      beat(i == 1, 1'b0, i);
      if (i == 16) begin
        checks++; if (overflow !== 1'b0) begin
          failures++; $display("FAIL ovf_at16 got=%b want=0", overflow); end
      end
    end
    idle();
    checks++; if (overflow !== 1'b1) begin
      failures++; $display("FAIL ovf_at17 got=%b want=1", overflow); end
    m_tready = 1'b1;
    repeat (17) cyc();
    checks++; if (q.size() != 16) begin
      failures++; $display("FAIL ovf_count got=%0d want=16", q.size()); end
    for (int k = 0; k < 16 && k < q.size(); k++) begin
      checks++; if (q[k].d !== FP_WL'(k + 1)) begin
        failures++; $display("FAIL ovf_beat%0d got=%0d want=%0d", k, q[k].d, k + 1); end
    end
    // Dropped beat must not have advanced the pixel count: 16 more complete the 32-pixel frame
    q.delete();
    for (int i = 17; i <= 32; i++) beat(1'b0, i == 32, i);
    idle();
    repeat (3) cyc();
    checks++; if (frame_err !== 1'b0 || frames_done !== 16'd1 || q.size() != 16) begin
      failures++; $display("FAIL ovf_pixcnt err=%b done=%0d n=%0d want 0/1/16", frame_err, frames_done, q.size()); end
  endtask

  task automatic test_full_push_pop();
    logic [FP_WL-1:0] want;
    do_reset();
    image_width = 8'd32; image_height = 8'd1;
    for (int i = 1; i <= 16; i++) beat(i == 1, 1'b0, i);
    m_tready = 1'b1;
    beat(1'b0, 1'b0, 99);
    idle();
    m_tready = 1'b0;
    cyc();
    checks++; if (overflow !== 1'b0 || m_tvalid !== 1'b1 || stall !== 1'b1) begin
      failures++; $display("FAIL full_pp_flags ovf=%b vld=%b stall=%b want 0/1/1", overflow, m_tvalid, stall); end
    m_tready = 1'b1;
    repeat (18) cyc();
    checks++; if (q.size() != 17) begin
      failures++; $display("FAIL full_pp_count got=%0d want=17", q.size()); end
    for (int k = 0; k < 17 && k < q.size(); k++) begin
      want = (k < 16) ? FP_WL'(k + 1) : FP_WL'(99);
      checks++; if (q[k].d !== want) begin
        failures++; $display("FAIL full_pp_beat%0d got=%0d want=%0d", k, q[k].d, want); end
    end
  endtask

  task automatic test_length_errors();
    do_reset();
    m_tready = 1'b1; image_width = 8'd2; image_height = 8'd2;
    beat(1'b1, 1'b0, 1);
    beat(1'b0, 1'b0, 2);
    checks++; if (frame_err !== 1'b0) begin
      failures++; $display("FAIL len_early_pre got=%b want=0", frame_err); end
    beat(1'b0, 1'b1, 3);
    idle();
    checks++; if (frame_err !== 1'b1) begin
      failures++; $display("FAIL len_early_last got=%b want=1", frame_err); end

    do_reset();
    m_tready = 1'b1;
    beat(1'b1, 1'b0, 1);
    beat(1'b0, 1'b0, 2);
    beat(1'b0, 1'b0, 3);
    checks++; if (frame_err !== 1'b0) begin
      failures++; $display("FAIL len_missing_pre got=%b want=0", frame_err); end
    beat(1'b0, 1'b0, 4);
    idle();
    checks++; if (frame_err !== 1'b1) begin
      failures++; $display("FAIL len_missing_last got=%b want=1", frame_err); end

    do_reset();
    beat(1'b0, 1'b0, 5);
    idle();
    checks++; if (frame_err !== 1'b1 || m_tvalid !== 1'b1 || m_tdata !== 16'd5) begin
      failures++; $display("FAIL len_orphan err=%b vld=%b d=%0d want 1/1/5", frame_err, m_tvalid, m_tdata); end
  endtask

  task automatic test_reset_midframe();
    do_reset();
    image_width = 8'd16; image_height = 8'd1;
    beat(1'b0, 1'b0, 7);
    for (int i = 1; i <= 11; i++) beat(i == 1, 1'b0, i);
    idle();
    checks++; if (m_tvalid !== 1'b1 || stall !== 1'b1 || frame_err !== 1'b1) begin
      failures++; $display("FAIL mid_pre vld=%b stall=%b err=%b want 1/1/1", m_tvalid, stall, frame_err); end
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    checks++; if ({m_tvalid, stall, frame_err, overflow} !== 4'b0000 || frames_done !== 16'd0 || m_tdata !== '0) begin
      failures++; $display("FAIL mid_reset vld=%b stall=%b err=%b ovf=%b done=%0d d=%0d want all 0",
                           m_tvalid, stall, frame_err, overflow, frames_done, m_tdata); end
    image_width = 8'd1; image_height = 8'd1;
    beat(1'b1, 1'b1, 16'h55);
    idle();
    checks++; if ({m_tvalid, m_tuser, m_tlast} !== 3'b111 || m_tdata !== 16'h0055) begin
      failures++; $display("FAIL mid_1x1_beat vld=%b u=%b l=%b d=%h want 1/1/1/0055", m_tvalid, m_tuser, m_tlast, m_tdata); end
    m_tready = 1'b1;
    cyc();
    checks++; if (m_tvalid !== 1'b0 || frame_err !== 1'b0 || frames_done !== 16'd1) begin
      failures++; $display("FAIL mid_1x1_done vld=%b err=%b done=%0d want 0/0/1", m_tvalid, frame_err, frames_done); end
  endtask

  initial begin
    reset = 1'b1; m_tready = 1'b0;
    image_width = '0; image_height = '0;
    idle();
    test_reset();
    test_basic();
    test_backpressure();
    test_overflow();
    test_full_push_pop();
    test_length_errors();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
